// File: rtl/i2c_tmp101_target_if.sv
// Observation port for the TMP101-style I2C target.
// The target drives these signals; anything watching the block reads them.
// State encoding: 0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WR_DATA, 4 WR_ACK,
//                 5 RD_DATA, 6 RD_ACK, 7 WAIT_STOP.
`timescale 1ns/1ps
interface i2c_tmp101_target_if;
    logic [2:0]  state;
    logic [1:0]  pointer;
    logic [2:0]  bit_cnt;
    logic [15:0] snapshot;

    modport slave  (output state, pointer, bit_cnt, snapshot);
    modport master (input  state, pointer, bit_cnt, snapshot);
endinterface

// File: rtl/i2c_tmp101_target.sv
// TMP101-style I2C target: 7-bit address {ADDR_BASE, AddrSel}, a 2-bit
// pointer register, a live 16-bit temperature register (snapshotted per read)
// and an 8-bit configuration register. SCL is never stretched; SDA is only
// ever pulled low or released.
//
// Bus timing: data is sampled on the synchronized SCL rising edge, and the
// block only changes its SDA drive on the cycle after a synchronized SCL
// falling edge, so SDA never moves while SCL is high (no false START/STOP).
// ADDR/WR_DATA hand over to their ACK state on the 8th rising edge; the ACK
// states then drive on the next fall, see the ACK clock rise, and exit on the
// following fall. RD_DATA hands over to RD_ACK on the fall after the 8th bit.
`timescale 1ns/1ps
module i2c_tmp101_target #(
    parameter logic [4:0] ADDR_BASE = 5'b10010
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  AddrSel,
    input  logic [15:0] TempIn,
    input  logic        SCL,
    inout  wire         SDA,
    output logic        Busy,
    output logic        ReadDone,
    output logic [7:0]  ConfigReg,
    i2c_tmp101_target_if.slave dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    // Synchronizer stages (s1, s2) plus one history stage for edge detection.
    logic scl_s1_q, scl_s2_q, scl_s3_q;
    logic sda_s1_q, sda_s2_q, sda_s3_q;

    state_t      state_q,     state_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic        rw_q,        rw_d;
    logic        ack_rise_q,  ack_rise_d;   // ACK clock rise already seen
    logic        sda_oe_q,    sda_oe_d;     // 1 = pull SDA low
    logic        busy_q,      busy_d;
    logic        read_done_q, read_done_d;
    logic [7:0]  config_q,    config_d;
    logic [1:0]  pointer_q,   pointer_d;
    logic [15:0] snap_q,      snap_d;
    logic        byte_sel_q,  byte_sel_d;   // 0 = next read byte is MSB
    logic [1:0]  wr_cnt_q,    wr_cnt_d;     // data bytes seen, saturates at 2

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, tx_byte;

    assign scl_rise  = scl_s2_q & ~scl_s3_q;
    assign scl_fall  = ~scl_s2_q & scl_s3_q;
    assign start_det = scl_s2_q & scl_s3_q & sda_s3_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_s3_q & ~sda_s3_q & sda_s2_q;

    // Byte as it stands once the bit currently on the bus is shifted in.
    assign rx_byte = {shift_q[6:0], sda_s2_q};
    // Only pointer values 0 and 1 can ever be stored.
    assign tx_byte = (pointer_q == 2'd1) ? config_q
                   : (byte_sel_q ? snap_q[7:0] : snap_q[15:8]);

    // Bus line synchronizers; they free-run so the history is valid at reset release.
    always_ff @(posedge Clock) begin
        scl_s1_q <= SCL;
        scl_s2_q <= scl_s1_q;
        scl_s3_q <= scl_s2_q;
        sda_s1_q <= SDA;
        sda_s2_q <= sda_s1_q;
        sda_s3_q <= sda_s2_q;
    end

    // Protocol state register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            ack_rise_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            read_done_q <= 1'b0;
            config_q    <= 8'h00;
            pointer_q   <= 2'd0;
            snap_q      <= 16'h0000;
            byte_sel_q  <= 1'b0;
            wr_cnt_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ack_rise_q  <= ack_rise_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            read_done_q <= read_done_d;
            config_q    <= config_d;
            pointer_q   <= pointer_d;
            snap_q      <= snap_d;
            byte_sel_q  <= byte_sel_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // Next-state logic: START/STOP override every state, otherwise walk the frame.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ack_rise_d  = ack_rise_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        read_done_d = 1'b0;
        config_d    = config_q;
        pointer_d   = pointer_q;
        snap_d      = snap_q;
        byte_sel_d  = byte_sel_q;
        wr_cnt_d    = wr_cnt_q;

        if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 3'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_rise_d = 1'b0;
        end else if (stop_det) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_rise_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == {ADDR_BASE, AddrSel}) begin
                                state_d    = ST_ADDR_ACK;
                                busy_d     = 1'b1;
                                rw_d       = rx_byte[0];
                                ack_rise_d = 1'b0;
                                byte_sel_d = 1'b0;
                                wr_cnt_d   = 2'd0;
                                if (rx_byte[0]) begin
                                    snap_d = TempIn;
                                end
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            if (rw_q) begin
                                state_d    = ST_RD_DATA;
                                shift_d    = tx_byte;
                                sda_oe_d   = ~tx_byte[7];
                                byte_sel_d = ~byte_sel_q;
                            end else begin
                                state_d  = ST_WR_DATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_rise_d = 1'b0;
                            wr_cnt_d   = (wr_cnt_q == 2'd2) ? 2'd2 : wr_cnt_q + 2'd1;
                            if (wr_cnt_q == 2'd0) begin
                                // Pointer byte: only the low two bits select a register.
                                if (!rx_byte[1]) begin
                                    pointer_d = rx_byte[1:0];
                                    state_d   = ST_WR_ACK;
                                end else begin
                                    state_d = ST_WAIT_STOP;
                                end
                            end else begin
                                if ((wr_cnt_q == 2'd1) && (pointer_q == 2'd1)) begin
                                    config_d = rx_byte;
                                end
                                state_d = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            state_d    = ST_WR_DATA;
                            sda_oe_d   = 1'b0;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d  = ST_RD_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            read_done_d = 1'b1;
                            state_d     = ST_WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        state_d    = ST_RD_DATA;
                        bit_cnt_d  = 3'd0;
                        shift_d    = tx_byte;
                        sda_oe_d   = ~tx_byte[7];
                        byte_sel_d = ~byte_sel_q;
                    end
                end
                default: begin
                    // IDLE and WAIT_STOP only leave on START/STOP.
                end
            endcase
        end
    end

    assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
    assign Busy      = busy_q;
    assign ReadDone  = read_done_q;
    assign ConfigReg = config_q;

    assign dbg.state    = state_q;
    assign dbg.pointer  = pointer_q;
    assign dbg.bit_cnt  = bit_cnt_q;
    assign dbg.snapshot = snap_q;

endmodule

// File: tb/tb_i2c_tmp101_target.sv
// Bench for i2c_tmp101_target: an I2C initiator driven from tasks, a
// transaction-level model of the target's registers, and an expected queue
// for read data.
`timescale 1ns/1ps
module tb_i2c_tmp101_target;

    localparam logic [4:0] ADDR_BASE = 5'b10010;
    localparam int Q = 8;   // quarter SCL period in system clocks

    // ---------------- clock / reset / DUT ----------------
    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  AddrSel;
    logic [15:0] TempIn;
    logic        SCL;
    logic        tb_sda_low;
    wire         SDA;
    logic        Busy;
    logic        ReadDone;
    logic [7:0]  ConfigReg;

    assign SDA = tb_sda_low ? 1'b0 : 1'bz;
    pullup (SDA);

    i2c_tmp101_target_if dbg_if ();

    i2c_tmp101_target #(.ADDR_BASE(ADDR_BASE)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .AddrSel   (AddrSel),
        .TempIn    (TempIn),
        .SCL       (SCL),
        .SDA       (SDA),
        .Busy      (Busy),
        .ReadDone  (ReadDone),
        .ConfigReg (ConfigReg),
        .dbg       (dbg_if.slave)
    );

    always #8 Clock = ~Clock;

    // ---------------- bus monitors ----------------
    int rd_done_cnt   = 0;   // cycles with ReadDone high
    int dut_drive_cnt = 0;   // cycles the target pulls SDA low
    int rule_viol     = 0;   // target pulling SDA low outside ADDR_ACK/WR_ACK/RD_DATA

    always @(negedge Clock) begin
        if (ReadDone) rd_done_cnt++;
        if (!tb_sda_low && SDA == 1'b0) begin
            dut_drive_cnt++;
            if (!(dbg_if.state inside {3'd2, 3'd4, 3'd5})) rule_viol++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] m_ptr = 2'd0;
    logic [7:0] m_cfg = 8'h00;
    logic [7:0] exp_q[$];

    function automatic logic addr_hit(input logic [7:0] a, input logic [1:0] sel);
        return a[7:1] == {ADDR_BASE, sel};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b0; wait_cyc(Q);
        SCL = 1'b1;        wait_cyc(Q);
        tb_sda_low = 1'b1; wait_cyc(Q);
        SCL = 1'b0;        wait_cyc(Q);
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1; wait_cyc(Q);
        SCL = 1'b1;        wait_cyc(Q);
        tb_sda_low = 1'b0; wait_cyc(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        tb_sda_low = !b; wait_cyc(Q);
        SCL = 1'b1;      wait_cyc(2 * Q);
        SCL = 1'b0;      wait_cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        tb_sda_low = 1'b0; wait_cyc(Q);
        SCL = 1'b1;        wait_cyc(Q);
        b = SDA;           wait_cyc(Q);
        SCL = 1'b0;        wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = !b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(!ack);
    endtask

    task automatic end_txn_stop();
        bus_stop();
        wait_cyc(4);
        check("stop_busy", 32'(Busy), 32'd0);
        check("stop_idle", 32'(dbg_if.state), 32'd0);
    endtask

    // ---------------- transactions ----------------
    task automatic do_write(input logic [7:0] addr_byte, input int n, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input bit with_stop);
        logic       acked;
        logic       exp_ack;
        logic       ptr_nack;
        logic [7:0] data [3];
        data[0] = d0; data[1] = d1; data[2] = d2;
        ptr_nack = 1'b0;
        bus_start();
        send_byte(addr_byte, acked);
        exp_ack = addr_hit(addr_byte, AddrSel);
        check("wr_addr_ack", 32'(acked), 32'(exp_ack));
        check("wr_busy", 32'(Busy), 32'(exp_ack));
        if (exp_ack) begin
            for (int i = 0; i < n; i++) begin
                send_byte(data[i], acked);
                if (i == 0) begin
                    exp_ack = (data[0] < 8'd2);
                    if (exp_ack) m_ptr = data[0][1:0];
                    else ptr_nack = 1'b1;
                end else begin
                    exp_ack = 1'b1;
                    if (i == 1 && m_ptr == 2'd1) m_cfg = data[1];
                end
                check("wr_data_ack", 32'(acked), 32'(exp_ack));
                if (!exp_ack) break;
            end
            check("wr_pointer", 32'(dbg_if.pointer), 32'(m_ptr));
            check("wr_config", 32'(ConfigReg), 32'(m_cfg));
            if (ptr_nack) check("wr_wait_stop", 32'(dbg_if.state), 32'd7);
        end
        if (with_stop) end_txn_stop();
    endtask

    task automatic do_read(input logic [7:0] addr_byte, input int n, input bit with_stop,
                           input bit change_temp, input logic [15:0] new_temp);
        logic        acked;
        logic        exp_ack;
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [15:0] snap;
        int          rd0;
        snap = TempIn;
        rd0  = rd_done_cnt;
        bus_start();
        send_byte(addr_byte, acked);
        exp_ack = addr_hit(addr_byte, AddrSel);
        check("rd_addr_ack", 32'(acked), 32'(exp_ack));
        check("rd_busy", 32'(Busy), 32'(exp_ack));
        if (exp_ack) begin
            if (change_temp) TempIn = new_temp;
            for (int i = 0; i < n; i++) begin
                if (m_ptr == 2'd0) exp_q.push_back((i % 2 == 0) ? snap[15:8] : snap[7:0]);
                else exp_q.push_back(m_cfg);
            end
            for (int i = 0; i < n; i++) begin
                recv_byte(got, i < n - 1);
                exp = exp_q.pop_front();
                check("rd_byte", 32'(got), 32'(exp));
            end
            check("rd_done_pulse", 32'(rd_done_cnt - rd0), 32'd1);
        end
        if (with_stop) end_txn_stop();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_400_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic       acked;
        logic       b;
        logic [7:0] got;
        logic [6:0] addr7;
        logic [7:0] ptr_byte;
        bit         with_stop;
        int         drv0;

        Reset = 1'b0; SCL = 1'b1; tb_sda_low = 1'b0;
        AddrSel = 2'b01; TempIn = 16'h1960;
        wait_cyc(6);
        check("rst_sda", 32'(SDA), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_readdone", 32'(ReadDone), 32'd0);
        check("rst_config", 32'(ConfigReg), 32'h00);
        check("rst_state", 32'(dbg_if.state), 32'd0);
        check("rst_pointer", 32'(dbg_if.pointer), 32'd0);
        check("rst_bitcnt", 32'(dbg_if.bit_cnt), 32'd0);
        check("rst_snapshot", 32'(dbg_if.snapshot), 32'd0);
        Reset = 1'b1;
        wait_cyc(6);

        // Temperature read: 0x19 then 0x60, NACK on the second byte.
        do_read(8'h93, 2, 1'b1, 1'b0, 16'h0000);

        // Foreign address: no ACK, target never touches SDA.
        bus_start();
        drv0 = dut_drive_cnt;
        send_byte(8'h95, acked);
        check("nomatch_ack", 32'(acked), 32'd0);
        recv_byte(got, 1'b0);
        check("nomatch_data", 32'(got), 32'hFF);
        check("nomatch_no_drive", 32'(dut_drive_cnt - drv0), 32'd0);
        check("nomatch_busy", 32'(Busy), 32'd0);
        end_txn_stop();

        // Configuration write then read back.
        do_write(8'h92, 3, 8'h01, 8'h60, 8'h00, 1'b1);
        do_read(8'h93, 1, 1'b1, 1'b0, 16'h0000);

        // Illegal pointer value: NACK, pointer kept, parked until STOP.
        do_write(8'h92, 1, 8'h00, 8'h00, 8'h00, 1'b1);
        do_write(8'h92, 1, 8'h03, 8'h00, 8'h00, 1'b0);
        wait_cyc(4 * Q);
        check("badptr_still_wait", 32'(dbg_if.state), 32'd7);
        end_txn_stop();

        // Snapshot held while TempIn moves; third byte wraps to the MSB.
        TempIn = 16'h1960;
        do_read(8'h93, 3, 1'b1, 1'b1, 16'h2000);

        // Reset in the middle of a read byte.
        TempIn = 16'h0000;
        bus_start();
        send_byte(8'h93, acked);
        check("rstmid_addr_ack", 32'(acked), 32'd1);
        for (int i = 0; i < 3; i++) recv_bit(b);
        check("rstmid_pre_drive", 32'(SDA), 32'd0);
        Reset = 1'b0;
        wait_cyc(1);
        check("rstmid_sda_release", 32'(SDA), 32'd1);
        wait_cyc(3);
        m_ptr = 2'd0; m_cfg = 8'h00;
        check("rstmid_busy", 32'(Busy), 32'd0);
        check("rstmid_state", 32'(dbg_if.state), 32'd0);
        check("rstmid_config", 32'(ConfigReg), 32'h00);
        Reset = 1'b1;
        drv0 = dut_drive_cnt;
        for (int i = 0; i < 5; i++) recv_bit(b);
        send_bit(1'b1);
        check("rstmid_ignored", 32'(dut_drive_cnt - drv0), 32'd0);
        check("rstmid_idle", 32'(dbg_if.state), 32'd0);
        end_txn_stop();
        TempIn = 16'h1960;
        do_read(8'h93, 1, 1'b1, 1'b0, 16'h0000);

        // Randomized transactions, some chained by repeated START.
        for (int t = 0; t < 20; t++) begin
            AddrSel = 2'($urandom_range(0, 3));
            TempIn  = 16'($urandom);
            addr7   = ($urandom_range(0, 4) != 0) ? {ADDR_BASE, AddrSel} : 7'($urandom_range(0, 127));
            with_stop = ($urandom_range(0, 3) != 0) || (t == 19);
            if ($urandom_range(0, 1) == 1) begin
                ptr_byte = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 3)) : 8'($urandom_range(0, 1));
                do_write({addr7, 1'b0}, $urandom_range(1, 3), ptr_byte,
                         8'($urandom), 8'($urandom), with_stop);
            end else begin
                do_read({addr7, 1'b1}, $urandom_range(1, 4), with_stop, 1'b0, 16'h0000);
            end
        end

        check("sda_drive_rule", 32'(rule_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_tmp101_target.md
I2C_TMP101_TARGET -- requirements
Module: i2c_tmp101_target

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset; ports are named Clock and Reset.
REQ-002 Parameter: ADDR_BASE, default 5'b10010, upper five bits of the 7-bit target address.
REQ-003 Port: Clock  input  1  system clock, 60 MHz.
REQ-004 Port: Reset  input  1  synchronous active-low reset.
REQ-005 Port: AddrSel  input  2  low address bits; target address = {ADDR_BASE, AddrSel}.
REQ-006 Port: TempIn  input  16  live temperature register value, MSB byte first on the bus.
REQ-007 Port: SCL  input  1  I2C clock from the initiator; the block never stretches it.
REQ-008 Port: SDA  inout  1  open-drain data line, driven only as 0 or Z.
REQ-009 Port: Busy  output  1  high from a START addressed to this target until STOP or the next START.
REQ-010 Port: ReadDone  output  1  one-cycle pulse when the initiator NACKs a read byte.
REQ-011 Port: ConfigReg  output  8  configuration register written over I2C.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer; all edge and START/STOP detection SHALL use the synchronized values, giving 2-cycle input latency.
REQ-013 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high; both SHALL be detected in any state.
REQ-014 Data SHALL be sampled on the synchronized SCL rising edge; SDA drive changes SHALL occur only on the cycle after a synchronized SCL falling edge.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-016 IDLE -> ADDR on START; ADDR shifts 8 bits MSB first, using a 3-bit bit counter that wraps at 7.
REQ-017 After the 8th bit: an address match -> ADDR_ACK (drive 0 for one SCL period); a mismatch -> WAIT_STOP with SDA released.
REQ-018 ADDR_ACK exit: R/W=1 -> RD_DATA; R/W=0 -> WR_DATA.
REQ-019 On ADDR_ACK entry with R/W=1, a 16-bit snapshot of TempIn SHALL be taken so both bytes are coherent.
REQ-020 Pointer register, 2 bits, reset 0.
REQ-021 The first write byte sets Pointer[1:0]; values 0 and 1 are ACKed; values 2 and 3 are NACKed, Pointer is unchanged, and the FSM goes to WAIT_STOP.
REQ-022 With Pointer=1, the second write byte loads ConfigReg and is ACKed.
REQ-023 Further write bytes are ACKed and discarded; with Pointer=0, all data bytes are ACKed and discarded.
REQ-024 Read, Pointer=0: bytes are snapshot[15:8], snapshot[7:0], then repeat from [15:8] while the initiator ACKs.
REQ-025 Read, Pointer=1: ConfigReg is returned on every byte.
REQ-026 In RD_DATA, the block drives 0 for a 0 bit and Z for a 1 bit.
REQ-027 In RD_ACK, SDA SHALL be released and the initiator ACK sampled; ACK -> RD_DATA with the next byte; NACK -> ReadDone pulse and WAIT_STOP.
REQ-028 A repeated START in any state SHALL go to ADDR, keep Pointer, and release SDA on the same cycle.
REQ-029 STOP in any state SHALL go to IDLE, release SDA, and drop Busy on the following cycle.
REQ-030 Busy SHALL assert on the cycle ADDR_ACK is entered.
REQ-031 The block SHALL never drive SDA outside ADDR_ACK, WR_ACK, and RD_DATA.

Reset
REQ-032 While Reset=0, the block SHALL hold IDLE with SDA=Z, Busy=0, ReadDone=0, ConfigReg=8'h00, Pointer=0, bit counter=0, and the snapshot cleared to 0.
REQ-033 Reset asserted mid-transfer SHALL release SDA on the next clock; after release, the block SHALL ignore the bus until the next START.

Verification
REQ-034 Scenario: AddrSel=2'b01, TempIn=16'h1960, initiator sends START, 0x93, then ACK, NACK -> ACK on address; bytes 0x19 then 0x60; ReadDone pulses once; Busy falls after STOP.
REQ-035 Scenario: address 0x95 sent with AddrSel=2'b01 -> no ACK (SDA stays Z for the whole frame); Busy stays 0.
REQ-036 Scenario: write 0x92, 0x01, 0x60, STOP, then read 0x93 with NACK -> all three bytes ACKed; ConfigReg=8'h60; read returns 0x60.
REQ-037 Scenario: write 0x92, 0x03 -> address ACKed, pointer byte NACKed; Pointer stays 0; state is WAIT_STOP until STOP.
REQ-038 Scenario: TempIn changes 0x1960 -> 0x2000 after the address ACK; read with ACK, ACK, NACK -> bytes 0x19, 0x60, 0x19 (snapshot held, wraps to MSB).
REQ-039 Scenario: Reset=0 during the 4th bit of a read byte -> SDA=Z next cycle; after release, a fresh START plus 0x93 is served normally.
